// File: rtl/pe_row_drain.sv
// pe_row_drain: end-of-row consumer of a mesh PE's packed {addr,data} word.
// While a pass is capturing it keeps every word that is not the idle sentinel
// MAX_INT. Kept words are buffered in a small FIFO and presented on a
// valid/ready stream. The block counts words per pass and flags when the pass
// is complete and the FIFO has drained.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous active-low reset
//   i_start    pulse; starts a new pass (flush FIFO, clear count and flags)
//   i_PE       PE word, addr in the MSBs, data in the LSBs
//   o_valid    head word available
//   i_ready    consumer takes the head word when o_valid && i_ready
//   o_addr     head word address field (0 while o_valid=0)
//   o_data     head word data field (0 while o_valid=0)
//   o_count    non-sentinel words seen this pass, including dropped ones
//   o_overflow sticky; a word was dropped because the FIFO was full
//   o_done     pass complete and FIFO drained; held until i_start or reset
//
// state   | meaning
// IDLE    | after reset, waiting for i_start; nothing is captured
// CAPTURE | pushing non-sentinel words until N have been seen
// DRAIN   | capture finished, waiting for the FIFO to empty
// DONE    | pass complete, o_done high
module pe_row_drain #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 3,
   parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = {(ADDR_WIDTH+DATA_WIDTH){1'b1}},
   parameter int N          = 4,
   parameter int DEPTH      = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_start,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE,
   output logic                             o_valid,
   input  logic                             i_ready,
   output logic [ADDR_WIDTH-1:0]            o_addr,
   output logic [DATA_WIDTH-1:0]            o_data,
   output logic [$clog2(N+1)-1:0]           o_count,
   output logic                             o_overflow,
   output logic                             o_done
);

   localparam int W  = ADDR_WIDTH + DATA_WIDTH;
   localparam int CW = $clog2(N + 1);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

   state_t        state;
   logic [W-1:0]  mem [DEPTH];
   // One extra pointer bit so that full and empty are distinguishable.
   logic [PW:0]   wr_ptr;
   logic [PW:0]   rd_ptr;
   logic [PW:0]   occupancy;
   logic [W-1:0]  head;
   logic          empty;
   logic          full;
   logic          pop;
   logic          push_req;
   logic          wr_en;
   logic          last_pop;

   assign occupancy = wr_ptr - rd_ptr;
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head      = mem[rd_ptr[PW-1:0]];

   assign o_valid   = !empty;
   assign o_addr    = o_valid ? head[W-1:DATA_WIDTH] : '0;
   assign o_data    = o_valid ? head[DATA_WIDTH-1:0] : '0;

   // i_start flushes the FIFO, so neither a pop nor a push happens that cycle.
   assign pop       = o_valid && i_ready && !i_start;
   assign push_req  = (state == CAPTURE) && !i_start && (i_PE != MAX_INT);
   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign wr_en     = push_req && (!full || pop);
   assign last_pop  = pop && (occupancy == (PW+1)'(1));

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[PW-1:0]] <= i_PE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_count    <= '0;
         o_overflow <= 1'b0;
         o_done     <= 1'b0;
      end else if (i_start) begin
         state      <= CAPTURE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_count    <= '0;
         o_overflow <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         case (state)
            CAPTURE: begin
               if (push_req) begin
                  // Dropped words still count so that the pass always terminates.
                  o_count <= o_count + 1'b1;
                  if (full && !pop) begin
                     o_overflow <= 1'b1;
                  end
                  if (o_count == CW'(N - 1)) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (empty || last_pop) begin
                  state  <= DONE;
                  o_done <= 1'b1;
               end
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_row_drain.sv
`timescale 1ns/1ps
module tb_pe_row_drain;

   localparam logic [5:0] SENT = 6'b111_111;
   localparam int P_IDLE = 0, P_CAP = 1, P_DRAIN = 2, P_DONE = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_start;
   logic       i_ready;
   logic [5:0] i_PE;

   always #5 clk = ~clk;

   logic       v1, v4, v6, ov1, ov4, ov6, dn1, dn4, dn6;
   logic [2:0] a1, a4, a6, d1, d4, d6;
   logic [0:0] c1;
   logic [2:0] c4, c6;

   pe_row_drain #(.N(1)) u_n1 (
      .clk(clk), .rst(rst), .i_start(i_start), .i_PE(i_PE), .o_valid(v1), .i_ready(i_ready),
      .o_addr(a1), .o_data(d1), .o_count(c1), .o_overflow(ov1), .o_done(dn1));
   pe_row_drain #(.N(4)) u_n4 (
      .clk(clk), .rst(rst), .i_start(i_start), .i_PE(i_PE), .o_valid(v4), .i_ready(i_ready),
      .o_addr(a4), .o_data(d4), .o_count(c4), .o_overflow(ov4), .o_done(dn4));
   pe_row_drain #(.N(6)) u_n6 (
      .clk(clk), .rst(rst), .i_start(i_start), .i_PE(i_PE), .o_valid(v6), .i_ready(i_ready),
      .o_addr(a6), .o_data(d6), .o_count(c6), .o_overflow(ov6), .o_done(dn6));

   // {valid, head(6), count(3), overflow, done}; head masked while not valid
   logic [11:0] obs [3];
   assign obs[0] = {v1, v1 ? {a1, d1} : 6'd0, 2'b00, c1, ov1, dn1};
   assign obs[1] = {v4, v4 ? {a4, d4} : 6'd0, c4, ov4, dn4};
   assign obs[2] = {v6, v6 ? {a6, d6} : 6'd0, c6, ov6, dn6};

   int total = 0;
   int bad   = 0;

   // Reference model: one queue per instance plus pass bookkeeping.
   logic [5:0] m_q [3][$];
   int         m_ph  [3];
   int         m_cnt [3];
   bit         m_ovf [3];
   bit         m_done[3];
   logic [5:0] out_q [3][$];

   function automatic int nk(int k);
      return (k == 0) ? 1 : ((k == 1) ? 4 : 6);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            m_q[k].delete();
            m_ph[k] = P_IDLE; m_cnt[k] = 0; m_ovf[k] = 0; m_done[k] = 0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            int sz;
            bit popped;
            sz = m_q[k].size();
            if (i_start) begin
               m_q[k].delete();
               m_ph[k] = P_CAP; m_cnt[k] = 0; m_ovf[k] = 0; m_done[k] = 0;
            end else begin
               popped = (sz > 0) && i_ready;
               if (popped) void'(m_q[k].pop_front());
               if (m_ph[k] == P_CAP && i_PE != SENT) begin
                  if (sz == 4 && !popped) m_ovf[k] = 1;
                  else m_q[k].push_back(i_PE);
                  m_cnt[k]++;
                  if (m_cnt[k] == nk(k)) m_ph[k] = P_DRAIN;
               end else if (m_ph[k] == P_DRAIN && (sz == 0 || (sz == 1 && popped))) begin
                  m_ph[k] = P_DONE; m_done[k] = 1;
               end
            end
         end
      end
   end

   function automatic logic [11:0] expv(int k);
      logic       v;
      logic [5:0] h;
      logic [2:0] c;
      v = m_q[k].size() > 0;
      h = v ? m_q[k][0] : 6'd0;
      c = m_cnt[k][2:0];
      return {v, h, c, m_ovf[k], m_done[k]};
   endfunction

   // Drive one cycle; record the head of every instance that pops on this edge.
   task automatic cyc(input bit s, input logic [5:0] pe, input bit r);
      i_start = s; i_PE = pe; i_ready = r;
      for (int k = 0; k < 3; k++)
         if (obs[k][11] && r && !s) out_q[k].push_back(obs[k][10:5]);
      @(posedge clk); @(negedge clk);
   endtask

   task automatic clear_out();
      for (int k = 0; k < 3; k++) out_q[k].delete();
   endtask

   task automatic test_reset();
      rst = 1'b0; i_start = 1'b0; i_ready = 1'b0; i_PE = 6'b000_100;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs[k] !== 12'd0) begin
            bad++; $display("FAIL reset_state inst%0d got=%h want=000", k, obs[k]);
         end
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 6'b000_100, 1);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== 12'd0 || obs[k] !== expv(k)) begin
               bad++; $display("FAIL idle_no_capture inst%0d got=%h want=000", k, obs[k]);
            end
         end
      end
   endtask

   task automatic test_n1();
      logic [5:0] pe [3] = '{SENT, 6'b000_100, SENT};
      bit         st [3] = '{1, 0, 0};
      clear_out();
      for (int i = 0; i < 3; i++) begin
         cyc(st[i], pe[i], 1);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== expv(k)) begin
               bad++; $display("FAIL n1_model inst%0d cyc%0d got=%h want=%h", k, i, obs[k], expv(k));
            end
         end
         if (i == 1) begin
            total++;
            if (obs[0][11:2] !== {1'b1, 6'b000_100, 3'd1}) begin
               bad++; $display("FAIL n1_head got=%h want=%h", obs[0][11:2], {1'b1, 6'b000_100, 3'd1});
            end
         end
      end
      total++;
      if (obs[0][11] !== 1'b0 || obs[0][0] !== 1'b1) begin
         bad++; $display("FAIL n1_done valid=%b done=%b want valid=0 done=1", obs[0][11], obs[0][0]);
      end
   endtask

   task automatic test_n4();
      logic [5:0] pe  [11] = '{SENT, SENT, 6'b001_010, SENT, 6'b010_011, 6'b011_001, 6'b100_110,
                               SENT, SENT, SENT, SENT};
      logic [5:0] exp [4]  = '{6'b001_010, 6'b010_011, 6'b011_001, 6'b100_110};
      clear_out();
      for (int i = 0; i < 11; i++) begin
         cyc(i == 0, pe[i], 1);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== expv(k)) begin
               bad++; $display("FAIL n4_model inst%0d cyc%0d got=%h want=%h", k, i, obs[k], expv(k));
            end
         end
      end
      total++;
      if (out_q[1].size() != 4) begin
         bad++; $display("FAIL n4_word_count got=%0d want=4", out_q[1].size());
      end
      for (int i = 0; i < 4 && i < out_q[1].size(); i++) begin
         total++;
         if (out_q[1][i] !== exp[i]) begin
            bad++; $display("FAIL n4_word%0d got=%b want=%b", i, out_q[1][i], exp[i]);
         end
      end
      total++;
      if (obs[1][4:0] !== {3'd4, 1'b0, 1'b1}) begin
         bad++; $display("FAIL n4_status got=%b want=%b", obs[1][4:0], {3'd4, 1'b0, 1'b1});
      end
   endtask

   task automatic test_backpressure();
      logic [5:0] w [6] = '{6'b001_001, 6'b010_010, 6'b011_011, 6'b100_100, 6'b101_101, 6'b110_110};
      clear_out();
      for (int i = 0; i < 13; i++) begin
         if (i == 0)     cyc(1, SENT, 0);
         else if (i < 7) cyc(0, w[i-1], 0);
         else            cyc(0, SENT, 1);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== expv(k)) begin
               bad++; $display("FAIL bp_model inst%0d cyc%0d got=%h want=%h", k, i, obs[k], expv(k));
            end
         end
         if (i == 6) begin
            total++;
            if (obs[2][11:1] !== {1'b1, w[0], 3'd6, 1'b1}) begin
               bad++; $display("FAIL bp_overflow got=%h want=%h", obs[2][11:1], {1'b1, w[0], 3'd6, 1'b1});
            end
         end
      end
      total++;
      if (out_q[2].size() != 4) begin
         bad++; $display("FAIL bp_word_count got=%0d want=4", out_q[2].size());
      end
      for (int i = 0; i < 4 && i < out_q[2].size(); i++) begin
         total++;
         if (out_q[2][i] !== w[i]) begin
            bad++; $display("FAIL bp_word%0d got=%b want=%b", i, out_q[2][i], w[i]);
         end
      end
      total++;
      if (obs[2][0] !== 1'b1) begin
         bad++; $display("FAIL bp_done got=%b want=1", obs[2][0]);
      end
   endtask

   task automatic test_full_push_pop();
      logic [5:0] w [6] = '{6'b000_001, 6'b001_000, 6'b010_101, 6'b101_010, 6'b110_001, 6'b011_110};
      clear_out();
      for (int i = 0; i < 13; i++) begin
         if (i == 0)     cyc(1, SENT, 0);
         else if (i < 5) cyc(0, w[i-1], 0);
         else if (i < 7) cyc(0, w[i-1], 1);
         else            cyc(0, SENT, 1);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== expv(k)) begin
               bad++; $display("FAIL fpp_model inst%0d cyc%0d got=%h want=%h", k, i, obs[k], expv(k));
            end
         end
      end
      total++;
      if (out_q[2].size() != 6) begin
         bad++; $display("FAIL fpp_word_count got=%0d want=6", out_q[2].size());
      end
      for (int i = 0; i < 6 && i < out_q[2].size(); i++) begin
         total++;
         if (out_q[2][i] !== w[i]) begin
            bad++; $display("FAIL fpp_word%0d got=%b want=%b", i, out_q[2][i], w[i]);
         end
      end
      total++;
      if (obs[2][4:0] !== {3'd6, 1'b0, 1'b1}) begin
         bad++; $display("FAIL fpp_status got=%b want=%b", obs[2][4:0], {3'd6, 1'b0, 1'b1});
      end
   endtask

   task automatic test_restart();
      clear_out();
      for (int i = 0; i < 14; i++) begin
         if (i == 0 || i == 3) cyc(1, SENT, 0);
         else if (i < 3)       cyc(0, 6'(i + 9), 0);
         else if (i < 10)      cyc(0, 6'(i * 5), 1);
         else                  cyc(0, SENT, 1);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== expv(k)) begin
               bad++; $display("FAIL restart_model inst%0d cyc%0d got=%h want=%h", k, i, obs[k], expv(k));
            end
         end
         if (i == 3) begin
            total++;
            if (obs[2][11] !== 1'b0 || obs[2][4:2] !== 3'd0) begin
               bad++; $display("FAIL restart_flush valid=%b count=%0d want valid=0 count=0", obs[2][11], obs[2][4:2]);
            end
         end
      end
      total++;
      if (obs[2][4:0] !== {3'd6, 1'b0, 1'b1}) begin
         bad++; $display("FAIL restart_status got=%b want=%b", obs[2][4:0], {3'd6, 1'b0, 1'b1});
      end
   endtask

   task automatic test_random();
      bit         s;
      bit         r;
      logic [5:0] pe;
      for (int i = 0; i < 600; i++) begin
         s  = (i % 60 == 0) || ($urandom_range(0, 49) == 0);
         r  = ($urandom_range(0, 2) != 0);
         pe = ($urandom_range(0, 3) == 0) ? SENT : 6'($urandom_range(0, 62));
         cyc(s, pe, r);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== expv(k)) begin
               bad++; $display("FAIL random_model inst%0d cyc%0d got=%h want=%h", k, i, obs[k], expv(k));
            end
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      cyc(1, SENT, 0);
      for (int i = 0; i < 6; i++) cyc(0, 6'(i + 1), 0);
      cyc(0, SENT, 1);
      #2 rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs[k] !== 12'd0) begin
            bad++; $display("FAIL async_reset inst%0d got=%h want=000", k, obs[k]);
         end
      end
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 6'b010_001, 1);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== 12'd0 || obs[k] !== expv(k)) begin
               bad++; $display("FAIL post_reset_idle inst%0d got=%h want=000", k, obs[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_n1();
      test_n4();
      test_backpressure();
      test_full_push_pop();
      test_restart();
      test_random();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
